// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_next_unit
// Purpose  : Program counter with sequential, branch, jump, call and return
//            next-address selection. Define RAS_EN to add the return stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter int                ADDR_W    = 10,
    parameter int                OFF_W     = 10,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [OFF_W-1:0]  br_offset,
    input  logic              jmp,
    input  logic [ADDR_W-1:0] jmp_addr,
    input  logic              call,
    input  logic              ret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inc,
    output logic [ADDR_W-1:0] br_target,
    output logic              pc_valid,
    output logic              redirect,
    output logic              ras_empty,
    output logic              ras_err
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    logic [ADDR_W-1:0] r_pc;
    logic              r_pc_valid;
    logic              r_redirect;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_off_ext;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_redirect;

    assign w_pc_inc    = r_pc + c_addr_one;
    assign w_off_ext   = ADDR_W'($signed(br_offset));
    assign w_br_target = w_pc_inc + w_off_ext;

`ifdef RAS_EN
    localparam int                c_ptr_w    = $clog2(RAS_DEPTH);
    localparam int                c_cnt_w    = $clog2(RAS_DEPTH + 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(RAS_DEPTH);

    logic [ADDR_W-1:0]  r_stack [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_sp;
    logic [c_cnt_w-1:0] r_count;
    logic               r_err;
    logic [c_ptr_w-1:0] w_top_idx;
    logic [c_ptr_w-1:0] w_wr_idx;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_swap;
    logic               w_err_set;

    // r_sp is the next free slot; once full it also points at the oldest entry
    assign w_top_idx = r_sp - c_ptr_one;
    assign w_wr_idx  = w_swap ? w_top_idx : r_sp;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_cnt_full);

    always_comb begin
        w_next_pc  = w_pc_inc;
        w_redirect = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_swap     = 1'b0;
        w_err_set  = 1'b0;
        if (ret && !w_empty) begin
            w_next_pc  = r_stack[w_top_idx];
            w_redirect = 1'b1;
            w_swap     = call;
            w_pop      = !call;
        end else if (ret && !call) begin
            w_err_set  = 1'b1;
        end else if (call) begin
            w_next_pc  = jmp_addr;
            w_redirect = 1'b1;
            w_push     = 1'b1;
            w_err_set  = ret | w_full;
        end else if (jmp) begin
            w_next_pc  = jmp_addr;
            w_redirect = 1'b1;
        end else if (br_taken) begin
            w_next_pc  = w_br_target;
            w_redirect = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sp    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (!stall) begin
            if (w_push) begin
                r_sp <= r_sp + c_ptr_one;
                if (!w_full) begin
                    r_count <= r_count + c_cnt_one;
                end
            end else if (w_pop) begin
                r_sp    <= w_top_idx;
                r_count <= r_count - c_cnt_one;
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    // Entries are only read when the count says they are valid, so no reset
    always_ff @(posedge clk) begin
        if (!stall && (w_push || w_swap)) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign ras_empty = w_empty;
    assign ras_err   = r_err;
`else
    logic w_unused;
    assign w_unused = ret ^ RAS_DEPTH[0];

    always_comb begin
        w_next_pc  = w_pc_inc;
        w_redirect = 1'b0;
        if (call || jmp) begin
            w_next_pc  = jmp_addr;
            w_redirect = 1'b1;
        end else if (br_taken) begin
            w_next_pc  = w_br_target;
            w_redirect = 1'b1;
        end
    end

    assign ras_empty = 1'b1;
    assign ras_err   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_pc_valid <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_pc_valid <= 1'b1;
            if (stall) begin
                r_redirect <= 1'b0;
            end else begin
                r_pc       <= w_next_pc;
                r_redirect <= w_redirect;
            end
        end
    end

    assign pc        = r_pc;
    assign pc_inc    = w_pc_inc;
    assign br_target = w_br_target;
    assign pc_valid  = r_pc_valid;
    assign redirect  = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_next_unit
// Purpose  : Scoreboard bench for pc_next_unit (ADDR_W=10, OFF_W=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

    localparam int ADDR_W    = 10;
    localparam int OFF_W     = 8;
    localparam int RAS_DEPTH = 4;

    logic              clk       = 1'b0;
    logic              reset     = 1'b1;
    logic              stall     = 1'b0;
    logic              br_taken  = 1'b0;
    logic [OFF_W-1:0]  br_offset = '0;
    logic              jmp       = 1'b0;
    logic [ADDR_W-1:0] jmp_addr  = '0;
    logic              call      = 1'b0;
    logic              ret       = 1'b0;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] br_target;
    logic              pc_valid;
    logic              redirect;
    logic              ras_empty;
    logic              ras_err;

    pc_next_unit #(
        .ADDR_W    (ADDR_W),
        .OFF_W     (OFF_W),
        .RESET_PC  ('0),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_offset (br_offset),
        .jmp       (jmp),
        .jmp_addr  (jmp_addr),
        .call      (call),
        .ret       (ret),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .br_target (br_target),
        .pc_valid  (pc_valid),
        .redirect  (redirect),
        .ras_empty (ras_empty),
        .ras_err   (ras_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic              redirect;
        logic              empty;
        logic              err;
    } exp_t;

    exp_t              sb [$];
    logic [ADDR_W-1:0] m_pc = '0;
    logic [ADDR_W-1:0] m_stack [$];
    logic              m_err = 1'b0;
    int                tests_run    = 0;
    int                tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of controls, predict the result, then compare after the edge
    task automatic cycle(input logic s, input logic b, input logic [OFF_W-1:0] off,
                         input logic j, input logic [ADDR_W-1:0] ja,
                         input logic c, input logic r);
        logic [ADDR_W-1:0] inc, sext, tgt, nxt, top;
        logic              rd;
        bit                done;
        exp_t              e;
        stall = s; br_taken = b; br_offset = off; jmp = j; jmp_addr = ja; call = c; ret = r;
        inc  = m_pc + 1'b1;
        sext = {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
        tgt  = inc + sext;
        #1;
        check("pc_inc", pc_inc, inc);
        check("br_target", br_target, tgt);
        nxt  = inc;
        rd   = 1'b0;
        done = 1'b0;
        if (s) begin
            nxt = m_pc;
        end else begin
`ifdef RAS_EN
            if (r && m_stack.size() > 0) begin
                top = m_stack[$];
                void'(m_stack.pop_back());
                if (c) m_stack.push_back(inc);
                nxt = top; rd = 1'b1; done = 1'b1;
            end else if (r && !c) begin
                m_err = 1'b1; done = 1'b1;
            end else if (c) begin
                if (r) m_err = 1'b1;
                if (m_stack.size() == RAS_DEPTH) begin
                    void'(m_stack.pop_front());
                    m_err = 1'b1;
                end
                m_stack.push_back(inc);
                nxt = ja; rd = 1'b1; done = 1'b1;
            end
`else
            if (c) begin
                nxt = ja; rd = 1'b1; done = 1'b1;
            end
`endif
            if (!done && j) begin
                nxt = ja; rd = 1'b1;
            end else if (!done && b) begin
                nxt = tgt; rd = 1'b1;
            end
        end
        m_pc       = nxt;
        e.pc       = nxt;
        e.redirect = rd;
        e.empty    = (m_stack.size() == 0);
        e.err      = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("redirect", redirect, e.redirect);
            check("ras_empty", ras_empty, e.empty);
            check("ras_err", ras_err, e.err);
        end
        stall = 1'b0; br_taken = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic seq();
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_jmp(input logic [ADDR_W-1:0] a);
        cycle(1'b0, 1'b0, '0, 1'b1, a, 1'b0, 1'b0);
    endtask

    task automatic do_call(input logic [ADDR_W-1:0] a);
        cycle(1'b0, 1'b0, '0, 1'b0, a, 1'b1, 1'b0);
    endtask

    task automatic do_ret();
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_pc", pc, 0);
        check("rst_pc_valid", pc_valid, 0);
        check("rst_redirect", redirect, 0);
        check("rst_ras_empty", ras_empty, 1);
        check("rst_ras_err", ras_err, 0);
        #11;
        reset = 1'b0;
        repeat (3) seq();
        check("pc_after_3", pc, 3);
        check("pc_valid_up", pc_valid, 1);

        // Asynchronous reset mid-cycle, after state has been disturbed
        do_call(10'h155);
        #2;
        reset = 1'b1;
        #1;
        check("async_pc", pc, 0);
        check("async_pc_valid", pc_valid, 0);
        check("async_redirect", redirect, 0);
        check("async_ras_empty", ras_empty, 1);
        check("async_ras_err", ras_err, 0);
        #1;
        reset = 1'b0;
        m_pc = '0;
        m_stack.delete();
        m_err = 1'b0;
        sb.delete();

        // Branch wrap and negative offset
        do_jmp(10'h3FE);
        cycle(1'b0, 1'b1, 8'h05, 1'b0, '0, 1'b0, 1'b0);
        seq();
        do_jmp(10'h010);
        cycle(1'b0, 1'b1, 8'hF0, 1'b0, '0, 1'b0, 1'b0);

        // Priority and stall
        cycle(1'b0, 1'b1, 8'h05, 1'b1, 10'h100, 1'b0, 1'b0);
        seq();
        cycle(1'b1, 1'b0, '0, 1'b1, 10'h100, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 10'h100, 1'b0, 1'b0);
        do_jmp(10'h100);

`ifdef RAS_EN
        do_jmp(10'h020);
        do_call(10'h200);
        do_call(10'h300);
        do_ret();
        do_ret();
        for (int i = 0; i < 5; i++) do_call(10'h040 + 10'(i * 16));
        for (int i = 0; i < 5; i++) do_ret();
        do_call(10'h1A0);
        cycle(1'b0, 1'b0, '0, 1'b0, 10'h3A0, 1'b1, 1'b1);
        do_ret();
        // Combined call/return on an empty stack behaves as a call
        cycle(1'b0, 1'b0, '0, 1'b0, 10'h2B0, 1'b1, 1'b1);
        do_ret();
`else
        do_call(10'h080);
        do_ret();
        cycle(1'b0, 1'b1, 8'h02, 1'b0, '0, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
